mult_operand_gate: RTL and testbench

- Issue stage directly upstream of exact_mult_8bit; also captures the multiplier's product.
- Accepts operand pairs over a valid/ready handshake and loads the multiplier's operand registers only when a real multiply is required.
- Zero-operand and repeated-operand requests skip the multiplier entirely: its inputs do not toggle and the result comes from a shortcut path.
- gate_en is exported as the clock-gate enable for the multiplier operand registers.

---
 rtl/mult_operand_gate.sv | 96 +++++++++
 tb/tb_mult_operand_gate.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mult_operand_gate.sv
// mult_operand_gate: issue stage that loads exact_mult_8bit operands only for real multiplies and shortcuts zero/repeat requests
module mult_operand_gate #(
  parameter bit ZERO_SKIP = 1'b1,
  parameter bit REPEAT_SKIP = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_y,
  output logic             gate_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_y,
  output logic             out_skip,
  output logic [CNT_W-1:0] cnt_mul,
  output logic [CNT_W-1:0] cnt_skip
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [15:0] out_y_q, out_y_d, last_y_q, last_y_d;
  logic out_skip_q, out_skip_d, have_last_q, have_last_d;
  logic [CNT_W-1:0] cnt_mul_q, cnt_mul_d, cnt_skip_q, cnt_skip_d;
  logic accept, zskip, rskip;
  assign in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
  assign accept = in_valid && in_ready;
  assign zskip = ZERO_SKIP && (in_a == 8'd0 || in_b == 8'd0);
  assign rskip = REPEAT_SKIP && have_last_q && in_a == mul_a_q && in_b == mul_b_q;
  assign gate_en = accept && !zskip && !rskip;
  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    out_y_d = out_y_q;
    last_y_d = last_y_q;
    out_skip_d = out_skip_q;
    have_last_d = have_last_q;
    cnt_mul_d = cnt_mul_q;
    cnt_skip_d = cnt_skip_q;
    if (state_q == EXEC) begin
      out_y_d = mul_y;
      last_y_d = mul_y;
      out_skip_d = 1'b0;
      state_d = HOLD;
    end
    if (state_q == HOLD && out_ready && !in_valid) state_d = IDLE;
    if (gate_en) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
      have_last_d = 1'b1;
      cnt_mul_d = &cnt_mul_q ? cnt_mul_q : cnt_mul_q + CNT_W'(1);
      state_d = EXEC;
    end else if (accept) begin
      out_y_d = zskip ? 16'd0 : last_y_q;
      out_skip_d = 1'b1;
      cnt_skip_d = &cnt_skip_q ? cnt_skip_q : cnt_skip_q + CNT_W'(1);
      state_d = HOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mul_a_q <= '0;
      mul_b_q <= '0;
      out_y_q <= '0;
      last_y_q <= '0;
      out_skip_q <= 1'b0;
      have_last_q <= 1'b0;
      cnt_mul_q <= '0;
      cnt_skip_q <= '0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      out_y_q <= out_y_d;
      last_y_q <= last_y_d;
      out_skip_q <= out_skip_d;
      have_last_q <= have_last_d;
      cnt_mul_q <= cnt_mul_d;
      cnt_skip_q <= cnt_skip_d;
    end
  end
  assign out_valid = state_q == HOLD;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign out_y = out_y_q;
  assign out_skip = out_skip_q;
  assign cnt_mul = cnt_mul_q;
  assign cnt_skip = cnt_skip_q;
endmodule

// File: tb/tb_mult_operand_gate.sv
// tb_mult_operand_gate: table-driven and hand-sequenced checks of the operand gate with a behavioural multiplier
module tb_mult_operand_gate;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, gate_en, out_valid, out_skip;
  logic [7:0] in_a = '0, in_b = '0, mul_a, mul_b;
  logic [15:0] mul_y, out_y;
  logic [3:0] cnt_mul, cnt_skip;
  int n_pass = 0, n_total = 0;
  typedef struct {int a; int b; int y; int skip; int lat; int ma; int mb; int cm; int cs;} vec_t;
  vec_t vt[8];
  always #5 clk = ~clk;
  assign mul_y = 16'(mul_a) * 16'(mul_b);
  mult_operand_gate #(.ZERO_SKIP(1'b1), .REPEAT_SKIP(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .gate_en(gate_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_skip(out_skip), .cnt_mul(cnt_mul), .cnt_skip(cnt_skip)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask
  task automatic issue(input vec_t v);
    int lat;
    in_a = 8'(v.a);
    in_b = 8'(v.b);
    in_valid = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 1);
    chk("gate_en", 32'(gate_en), 32'(v.skip == 0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("out_y", 32'(out_y), 32'(v.y));
    chk("out_skip", 32'(out_skip), 32'(v.skip));
    chk("mul_a", 32'(mul_a), 32'(v.ma));
    chk("mul_b", 32'(mul_b), 32'(v.mb));
    chk("cnt_mul", 32'(cnt_mul), 32'(v.cm));
    chk("cnt_skip", 32'(cnt_skip), 32'(v.cs));
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    vt[0] = '{3, 5, 15, 0, 2, 3, 5, 1, 0};
    vt[1] = '{0, 200, 0, 1, 1, 3, 5, 1, 1};
    vt[2] = '{3, 5, 15, 1, 1, 3, 5, 1, 2};
    vt[3] = '{5, 3, 15, 0, 2, 5, 3, 2, 2};
    vt[4] = '{255, 255, 65025, 0, 2, 255, 255, 3, 2};
    vt[5] = '{255, 255, 65025, 1, 1, 255, 255, 3, 3};
    vt[6] = '{200, 0, 0, 1, 1, 255, 255, 3, 4};
    vt[7] = '{255, 255, 65025, 1, 1, 255, 255, 3, 5};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst gate_en", 32'(gate_en), 0);
    chk("rst out_y", 32'(out_y), 0);
    chk("rst out_skip", 32'(out_skip), 0);
    chk("rst mul_ab", 32'({mul_a, mul_b}), 0);
    chk("rst cnts", 32'({cnt_mul, cnt_skip}), 0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) issue(vt[i]);
    out_ready = 1'b0;
    in_a = 8'd3;
    in_b = 8'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("stall first valid", 32'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall out_valid", 32'(out_valid), 1);
      chk("stall out_y", 32'(out_y), 15);
      chk("stall in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_a = 8'd16;
    in_b = 8'd16;
    in_valid = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 1);
    chk("release gate_en", 32'(gate_en), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("exec no valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("16x16 valid", 32'(out_valid), 1);
    chk("16x16 out_y", 32'(out_y), 256);
    chk("16x16 skip", 32'(out_skip), 0);
    chk("16x16 cnt_mul", 32'(cnt_mul), 5);
    @(posedge clk);
    @(negedge clk);
    in_a = 8'd7;
    in_b = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 0);
    chk("mid rst in_ready", 32'(in_ready), 1);
    chk("mid rst out_y", 32'(out_y), 0);
    chk("mid rst mul_ab", 32'({mul_a, mul_b}), 0);
    chk("mid rst cnts", 32'({cnt_mul, cnt_skip}), 0);
    @(negedge clk);
    chk("mid rst still idle", 32'(out_valid), 0);
    issue('{7, 9, 63, 0, 2, 7, 9, 1, 0});
    for (int i = 0; i < 17; i++) issue('{0, i + 1, 0, 1, 1, 7, 9, 1, (i + 1 > 15) ? 15 : i + 1});
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
